axis_i2s_rx: RTL and testbench

I2S receiver that deserialises a stereo I2S stream (external clock master, e.g. a codec ADC or loopback of the I2S transmitter pins) into 64-bit AXI-Stream stereo frames. The frame format is identical to the one consumed by our I2S transmitter, so a receiver→transmitter chain passes audio unmodified. The block runs entirely in aclk. sclk, lrck and sdin are treated as asynchronous data inputs, oversampled and edge-detected; no logic is clocked by sclk.

---
 rtl/axis_i2s_rx.sv | 163 ++++++++++++++++
 tb/tb_axis_i2s_rx.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_i2s_rx.sv
// I2S (Philips) receiver: oversamples an externally clocked stereo stream in aclk and
// emits {left, 8'd0, right, 8'd0} frames on a single-entry AXI-Stream output register.
module axis_i2s_rx #(
    parameter int unsigned SLOT_BITS   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        aclk,
    input  logic        resetn,
    input  logic        i2s_sclk,
    input  logic        i2s_lrck,
    input  logic        i2s_sdin,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        locked,
    output logic        frame_err,
    output logic [15:0] overflow_cnt
);

    typedef enum logic [1:0] {StAlign, StLeft, StRight} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, lrck_sync_q, sdin_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, lrck_s, sdin_s;
    logic                   rise, boundary, slot_ok;

    state_e      state_q;
    logic        locked_q;
    logic        lrck_prev_q;
    logic [5:0]  bit_cnt_q;
    // The top bit of the 32-bit shift window is only ever read combinationally.
    logic [30:0] shreg_q;
    logic [31:0] shreg_d;
    logic [23:0] word;
    logic [23:0] left_q;
    logic [63:0] frame_q;
    logic        emit_q, err_q;

    logic [63:0] tdata_q;
    logic        tvalid_q, tlast_q, frame_err_q;
    logic [15:0] ovf_q;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            sclk_sync_q <= '0;
            lrck_sync_q <= '0;
            sdin_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk};
            lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
            sdin_sync_q <= {sdin_sync_q[SYNC_STAGES-2:0], i2s_sdin};
            sclk_prev_q <= sclk_s;
        end
    end

    always_comb begin
        sclk_s   = sclk_sync_q[SYNC_STAGES-1];
        lrck_s   = lrck_sync_q[SYNC_STAGES-1];
        sdin_s   = sdin_sync_q[SYNC_STAGES-1];
        rise     = sclk_s & ~sclk_prev_q;
        boundary = rise && (lrck_s != lrck_prev_q);
        shreg_d  = {shreg_q, sdin_s};
        word     = shreg_d[SLOT_BITS-1 -: 24];
        // The boundary bit is the previous slot's LSB, so a full slot has counted SLOT_BITS-1.
        slot_ok  = (7'(bit_cnt_q) + 7'd1) == 7'(SLOT_BITS);
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q     <= StAlign;
            locked_q    <= 1'b0;
            lrck_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            left_q      <= '0;
            frame_q     <= '0;
            emit_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            emit_q <= 1'b0;
            err_q  <= 1'b0;
            if (rise) begin
                shreg_q     <= shreg_d[30:0];
                lrck_prev_q <= lrck_s;
                if (boundary) begin
                    bit_cnt_q <= '0;
                end else if (bit_cnt_q != 6'd63) begin
                    bit_cnt_q <= bit_cnt_q + 6'd1;
                end
            end
            if (boundary) begin
                case (state_q)
                    StAlign: begin
                        if (!lrck_s) begin
                            state_q  <= StLeft;
                            locked_q <= 1'b1;
                        end
                    end
                    StLeft: begin
                        if (slot_ok) begin
                            left_q  <= word;
                            state_q <= StRight;
                        end else begin
                            err_q    <= 1'b1;
                            state_q  <= StAlign;
                            locked_q <= 1'b0;
                        end
                    end
                    StRight: begin
                        if (slot_ok) begin
                            frame_q <= {left_q, 8'd0, word, 8'd0};
                            emit_q  <= 1'b1;
                            state_q <= StLeft;
                        end else begin
                            err_q    <= 1'b1;
                            state_q  <= StAlign;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= StAlign;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= '0;
        end else begin
            frame_err_q <= err_q;
            if (emit_q) begin
                if (!tvalid_q || m_axis_tready) begin
                    tdata_q  <= frame_q;
                    tvalid_q <= 1'b1;
                    tlast_q  <= 1'b1;
                end else if (ovf_q != 16'hFFFF) begin
                    // Held frame wins; the new one is dropped and counted.
                    ovf_q <= ovf_q + 16'd1;
                end
            end else if (tvalid_q && m_axis_tready) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign locked        = locked_q;
    assign frame_err     = frame_err_q;
    assign overflow_cnt  = ovf_q;

endmodule

// File: tb/tb_axis_i2s_rx.sv
// Directed bench for axis_i2s_rx: drives a Philips I2S stream at aclk/4 and checks frames,
// latency, lock, backpressure, slot errors and reset behaviour.
module tb_axis_i2s_rx;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        sclk = 1'b0, lrck = 1'b0, sdin = 1'b0;
    logic        tready = 1'b1;
    logic [63:0] tdata;
    logic        tvalid, tlast, locked, frame_err;
    logic [15:0] ovf;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [63:0] log_data [0:255];
    logic        log_last [0:255];
    int          log_cyc  [0:255];
    int          n_log = 0;
    int          err_seen = 0;
    logic        last_bit = 1'b0;

    axis_i2s_rx #(.SLOT_BITS(32), .SYNC_STAGES(2)) dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .i2s_sclk      (sclk),
        .i2s_lrck      (lrck),
        .i2s_sdin      (sdin),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tlast  (tlast),
        .m_axis_tready (tready),
        .locked        (locked),
        .frame_err     (frame_err),
        .overflow_cnt  (ovf)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    // Log each handshake that will complete at the next rising edge.
    always @(negedge aclk) begin
        #1;
        if (tvalid && tready) begin
            if (n_log < 256) begin
                log_data[n_log] = tdata;
                log_last[n_log] = tlast;
                log_cyc[n_log]  = cyc;
            end
            n_log = n_log + 1;
        end
        if (frame_err) err_seen = err_seen + 1;
    end

    function automatic logic [63:0] fr(input logic [23:0] l, input logic [23:0] r);
        return {l, 8'd0, r, 8'd0};
    endfunction

    function automatic logic bitof(input logic [23:0] w, input int i);
        return (i < 24) ? w[23-i] : 1'b0;
    endfunction

    task automatic half(input logic s, input logic lr, input logic d);
        sclk = s;
        lrck = lr;
        sdin = d;
        repeat (2) @(negedge aclk);
    endtask

    task automatic send_bit(input logic lr, input logic d);
        half(1'b0, lr, d);
        half(1'b1, lr, d);
    endtask

    task automatic send_slot_tail(input logic lr, input logic [23:0] w, input int n);
        for (int i = 1; i < n; i++) send_bit(lr, bitof(w, i - 1));
        last_bit = bitof(w, n - 1);
    endtask

    task automatic send_slot(input logic lr, input logic [23:0] w, input int n);
        send_bit(lr, last_bit);
        send_slot_tail(lr, w, n);
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    task automatic start_stream();
        send_slot(1'b1, 24'h5A5A5A, 32);
    endtask

    task automatic flush();
        send_slot(1'b0, 24'h000000, 32);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        resetn = 1'b0;
        sclk = 1'b0;
        lrck = 1'b0;
        sdin = 1'b0;
        tready = 1'b1;
        repeat (3) @(negedge aclk);
        resetn = 1'b1;
        last_bit = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", tvalid); end
        checks++; if (tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata got %h exp 0", tdata); end
        checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", tlast); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        checks++; if (ovf !== 16'd0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", ovf); end
    endtask

    task automatic test_basic();
        int b;
        do_reset();
        b = n_log;
        start_stream();
        for (int i = 0; i < 4; i++) send_frame(24'h123456, 24'hABCDEF);
        flush();
        checks++; if (n_log - b !== 4) begin errors++; $display("FAIL basic_count got %0d exp 4", n_log - b); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_data[b+i] !== 64'h12345600_ABCDEF00) begin
                errors++; $display("FAIL basic_tdata[%0d] got %h exp 12345600abcdef00", i, log_data[b+i]);
            end
            checks++;
            if (log_last[b+i] !== 1'b1) begin
                errors++; $display("FAIL basic_tlast[%0d] got %b exp 1", i, log_last[b+i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_cyc[b+i+1] - log_cyc[b+i] !== 256) begin
                errors++; $display("FAIL basic_period[%0d] got %0d exp 256", i, log_cyc[b+i+1] - log_cyc[b+i]);
            end
        end
        checks++; if (ovf !== 16'd0) begin errors++; $display("FAIL basic_ovf got %0d exp 0", ovf); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL basic_locked got %b exp 1", locked); end
    endtask

    task automatic test_latency();
        int b;
        do_reset();
        b = n_log;
        send_slot(1'b1, 24'h0F0F0F, 10);
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lat_unlocked got %b exp 0", locked); end
        @(negedge aclk);
        send_slot(1'b0, 24'h234567, 32);
        #1;
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lat_locked got %b exp 1", locked); end
        checks++; if (n_log - b !== 0) begin errors++; $display("FAIL lat_partial got %0d frames exp 0", n_log - b); end
        @(negedge aclk);
        send_slot(1'b1, 24'h89ABCD, 32);
        half(1'b0, 1'b0, last_bit);
        sclk = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL lat_early got %b exp 0", tvalid); end
        @(negedge aclk);
        #1;
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL lat_ontime got %b exp 1", tvalid); end
        checks++;
        if (tdata !== fr(24'h234567, 24'h89ABCD)) begin
            errors++; $display("FAIL lat_tdata got %h exp %h", tdata, fr(24'h234567, 24'h89ABCD));
        end
        @(negedge aclk);
        send_slot_tail(1'b0, 24'h456789, 32);
        send_slot(1'b1, 24'hFEDCBA, 32);
        flush();
        checks++; if (n_log - b !== 2) begin errors++; $display("FAIL lat_count got %0d exp 2", n_log - b); end
        checks++;
        if (log_data[b+1] !== fr(24'h456789, 24'hFEDCBA)) begin
            errors++; $display("FAIL lat_second got %h exp %h", log_data[b+1], fr(24'h456789, 24'hFEDCBA));
        end
    endtask

    task automatic test_backpressure();
        int b;
        logic [23:0] l [1:5];
        logic [23:0] r [1:5];
        for (int i = 1; i <= 5; i++) begin
            l[i] = 24'h010101 * i;
            r[i] = 24'hF0F0F0 ^ l[i];
        end
        do_reset();
        b = n_log;
        start_stream();
        send_frame(l[1], r[1]);
        tready = 1'b0;
        send_frame(l[2], r[2]);
        send_frame(l[3], r[3]);
        send_frame(l[4], r[4]);
        #1;
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid got %b exp 1", tvalid); end
        checks++;
        if (tdata !== fr(l[1], r[1])) begin
            errors++; $display("FAIL bp_hold got %h exp %h", tdata, fr(l[1], r[1]));
        end
        checks++; if (ovf !== 16'd2) begin errors++; $display("FAIL bp_ovf got %0d exp 2", ovf); end
        @(negedge aclk);
        tready = 1'b1;
        send_frame(l[5], r[5]);
        flush();
        checks++; if (n_log - b !== 3) begin errors++; $display("FAIL bp_count got %0d exp 3", n_log - b); end
        checks++;
        if (log_data[b] !== fr(l[1], r[1])) begin
            errors++; $display("FAIL bp_first got %h exp %h", log_data[b], fr(l[1], r[1]));
        end
        checks++;
        if (log_data[b+1] !== fr(l[4], r[4])) begin
            errors++; $display("FAIL bp_fresh got %h exp %h", log_data[b+1], fr(l[4], r[4]));
        end
        checks++;
        if (log_data[b+2] !== fr(l[5], r[5])) begin
            errors++; $display("FAIL bp_next got %h exp %h", log_data[b+2], fr(l[5], r[5]));
        end
        checks++; if (ovf !== 16'd2) begin errors++; $display("FAIL bp_ovf_after got %0d exp 2", ovf); end
    endtask

    task automatic test_slot_error();
        int b;
        int e;
        do_reset();
        b = n_log;
        e = err_seen;
        start_stream();
        send_frame(24'h111111, 24'h222222);
        send_slot(1'b0, 24'h333333, 31);
        send_slot(1'b1, 24'h444444, 32);
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_unlocked got %b exp 0", locked); end
        checks++; if (err_seen - e !== 1) begin errors++; $display("FAIL err_pulses got %0d exp 1", err_seen - e); end
        @(negedge aclk);
        send_frame(24'h555555, 24'h666666);
        send_frame(24'h777777, 24'h888888);
        flush();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err_relock got %b exp 1", locked); end
        checks++; if (err_seen - e !== 1) begin errors++; $display("FAIL err_pulses_end got %0d exp 1", err_seen - e); end
        checks++; if (n_log - b !== 3) begin errors++; $display("FAIL err_count got %0d exp 3", n_log - b); end
        checks++;
        if (log_data[b] !== fr(24'h111111, 24'h222222)) begin
            errors++; $display("FAIL err_f1 got %h exp %h", log_data[b], fr(24'h111111, 24'h222222));
        end
        checks++;
        if (log_data[b+1] !== fr(24'h555555, 24'h666666)) begin
            errors++; $display("FAIL err_f3 got %h exp %h", log_data[b+1], fr(24'h555555, 24'h666666));
        end
        checks++;
        if (log_data[b+2] !== fr(24'h777777, 24'h888888)) begin
            errors++; $display("FAIL err_f4 got %h exp %h", log_data[b+2], fr(24'h777777, 24'h888888));
        end
    endtask

    task automatic test_emit_accept();
        int b;
        do_reset();
        b = n_log;
        start_stream();
        send_frame(24'hA1A1A1, 24'hB1B1B1);
        tready = 1'b0;
        send_frame(24'hA2A2A2, 24'hB2B2B2);
        half(1'b0, 1'b0, last_bit);
        sclk = 1'b1;
        repeat (3) @(negedge aclk);
        tready = 1'b1;
        @(negedge aclk);
        #1;
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL ea_tvalid got %b exp 1", tvalid); end
        checks++;
        if (tdata !== fr(24'hA2A2A2, 24'hB2B2B2)) begin
            errors++; $display("FAIL ea_tdata got %h exp %h", tdata, fr(24'hA2A2A2, 24'hB2B2B2));
        end
        checks++; if (ovf !== 16'd0) begin errors++; $display("FAIL ea_ovf got %0d exp 0", ovf); end
        @(negedge aclk);
        send_slot_tail(1'b0, 24'hA3A3A3, 32);
        send_slot(1'b1, 24'hB3B3B3, 32);
        flush();
        checks++; if (n_log - b !== 3) begin errors++; $display("FAIL ea_count got %0d exp 3", n_log - b); end
        checks++;
        if (log_data[b] !== fr(24'hA1A1A1, 24'hB1B1B1)) begin
            errors++; $display("FAIL ea_old got %h exp %h", log_data[b], fr(24'hA1A1A1, 24'hB1B1B1));
        end
        checks++;
        if (log_data[b+1] !== fr(24'hA2A2A2, 24'hB2B2B2)) begin
            errors++; $display("FAIL ea_new got %h exp %h", log_data[b+1], fr(24'hA2A2A2, 24'hB2B2B2));
        end
        checks++;
        if (log_data[b+2] !== fr(24'hA3A3A3, 24'hB3B3B3)) begin
            errors++; $display("FAIL ea_third got %h exp %h", log_data[b+2], fr(24'hA3A3A3, 24'hB3B3B3));
        end
    endtask

    task automatic test_reset_mid();
        int b;
        do_reset();
        start_stream();
        send_frame(24'hC1C1C1, 24'hD1D1D1);
        tready = 1'b0;
        send_frame(24'hC2C2C2, 24'hD2D2D2);
        #1;
        checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL rm_pending got %b exp 1", tvalid); end
        @(negedge aclk);
        resetn = 1'b0;
        sclk = 1'b0;
        lrck = 1'b0;
        sdin = 1'b0;
        @(negedge aclk);
        #1;
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rm_tvalid got %b exp 0", tvalid); end
        checks++; if (tdata !== 64'd0) begin errors++; $display("FAIL rm_tdata got %h exp 0", tdata); end
        checks++; if (tlast !== 1'b0) begin errors++; $display("FAIL rm_tlast got %b exp 0", tlast); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rm_locked got %b exp 0", locked); end
        checks++; if (ovf !== 16'd0) begin errors++; $display("FAIL rm_ovf got %0d exp 0", ovf); end
        @(negedge aclk);
        resetn = 1'b1;
        tready = 1'b1;
        last_bit = 1'b0;
        @(negedge aclk);
        b = n_log;
        start_stream();
        send_frame(24'hC3C3C3, 24'hD3D3D3);
        flush();
        checks++; if (n_log - b !== 1) begin errors++; $display("FAIL rm_count got %0d exp 1", n_log - b); end
        checks++;
        if (log_data[b] !== fr(24'hC3C3C3, 24'hD3D3D3)) begin
            errors++; $display("FAIL rm_frame got %h exp %h", log_data[b], fr(24'hC3C3C3, 24'hD3D3D3));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_backpressure();
        test_slot_error();
        test_emit_accept();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
